// File: rtl/lc3b_types_pkg.sv
// lc3b_types: shared LC-3b word, write-mask and memory-op types
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [2:0] {
    mop_ldr = 3'd0,
    mop_ldb = 3'd1,
    mop_ldi = 3'd2,
    mop_str = 3'd3,
    mop_stb = 3'd4,
    mop_sti = 3'd5
  } lc3b_memop;
  function automatic logic is_store(input logic [2:0] op);
    return op == mop_str || op == mop_stb || op == mop_sti;
  endfunction
  function automatic logic is_ind(input logic [2:0] op);
    return op == mop_ldi || op == mop_sti;
  endfunction
  function automatic logic is_known(input logic [2:0] op);
    return op <= 3'd5;
  endfunction
  function automatic logic is_byte(input logic [2:0] op);
    return op == mop_ldb || op == mop_stb;
  endfunction
endpackage

// File: rtl/lc3b_byte_lane.sv
// lc3b_byte_lane: byte-lane write replication, write mask and load-byte extraction
module lc3b_byte_lane
  import lc3b_types::*;
#(
  parameter logic LDB_SEXT = 1'b0
) (
  input  logic [2:0]  op,
  input  logic        addr0,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [15:0] lane_wdata,
  output logic [1:0]  wmask,
  output logic [15:0] load_data
);
  logic byte_op;
  logic [7:0] b;
  assign byte_op = is_byte(op);
  assign b = addr0 ? rdata[15:8] : rdata[7:0];
  assign lane_wdata = byte_op ? {2{wdata[7:0]}} : wdata;
  assign wmask = !byte_op ? 2'b11 : addr0 ? 2'b10 : 2'b01;
  assign load_data = !byte_op ? rdata : {{8{LDB_SEXT & b[7]}}, b};
endmodule

// File: rtl/lc3b_mem_access_unit.sv
// lc3b_mem_access_unit: multicycle LC-3b load/store stage with LDI/STI indirection
module lc3b_mem_access_unit
  import lc3b_types::*;
#(
  parameter logic LDB_SEXT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);
  localparam logic [1:0] S_IDLE = 2'd0, S_IND = 2'd1, S_ACCESS = 2'd2, S_DONE = 2'd3;
  logic [1:0] state;
  logic [2:0] op;
  lc3b_word addr, wdata, lane_wdata, load_data;
  lc3b_mem_wmask lane_wmask;
  logic hit;
  lc3b_byte_lane #(.LDB_SEXT(LDB_SEXT)) u_lane (
    .op(op), .addr0(addr[0]), .wdata(wdata), .rdata(mem_rdata),
    .lane_wdata(lane_wdata), .wmask(lane_wmask), .load_data(load_data)
  );
  assign hit = (mem_read | mem_write) & mem_resp;
  assign mem_address = is_byte(op) ? addr : {addr[15:1], 1'b0};
  assign mem_wmask = mem_write ? lane_wmask : 2'b00;
  assign mem_wdata = mem_write ? lane_wdata : 16'h0;
  // strobes rise one cycle after entering IND/ACCESS and drop on the edge after resp
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      rsp_valid <= state == S_DONE;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            op <= req_op;
            addr <= req_addr;
            wdata <= req_wdata;
            req_ready <= 1'b0;
            state <= is_ind(req_op) ? S_IND : is_known(req_op) ? S_ACCESS : S_DONE;
            if (!is_known(req_op)) rsp_data <= '0;
          end
        end
        S_IND: begin
          if (hit) begin
            addr <= {mem_rdata[15:1], 1'b0};
            mem_read <= 1'b0;
            state <= S_ACCESS;
          end else mem_read <= 1'b1;
        end
        S_ACCESS: begin
          if (hit) begin
            if (!is_store(op)) rsp_data <= load_data;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            state <= S_DONE;
          end else begin
            mem_read <= !is_store(op);
            mem_write <= is_store(op);
          end
        end
        default: begin
          state <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lc3b_mem_access_unit.sv
// tb_lc3b_mem_access_unit: scoreboard bench with a wait-state memory model
module tb_lc3b_mem_access_unit;
  import lc3b_types::*;
  logic clk = 0, reset_n = 0, req_valid = 0, mem_resp = 0, stray = 0;
  logic [2:0] req_op = 0;
  logic [15:0] req_addr = 0, req_wdata = 0, mem_rdata;
  logic req_ready, rsp_valid, mem_read, mem_write;
  logic [15:0] rsp_data, mem_address, mem_wdata;
  logic [1:0] mem_wmask;
  logic s_req_ready, s_rsp_valid, s_mem_read, s_mem_write;
  logic [15:0] s_rsp_data, s_mem_address, s_mem_wdata;
  logic [1:0] s_mem_wmask;
  lc3b_mem_access_unit #(.LDB_SEXT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  lc3b_mem_access_unit #(.LDB_SEXT(1'b1)) dut_sext (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .mem_address(s_mem_address),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_wmask(s_mem_wmask),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  always #5 clk = ~clk;
  typedef struct packed { logic [15:0] d0, d1; } rsp_t;
  typedef struct packed { logic [15:0] a, d; logic [1:0] m; } wr_t;
  rsp_t rsp_q[$];
  wr_t wr_q[$];
  logic [15:0] rd_log[$];
  logic [15:0] mem [0:32767];
  logic [15:0] last0 = 0, last1 = 0;
  int checks = 0, failures = 0, wait_n = 0, cnt = 0, rd_cycles = 0, wr_cycles = 0, rsp_count = 0;
  assign mem_rdata = mem[mem_address[15:1]];
  // memory model plus response/write scoreboards, all evaluated away from the active edge
  always @(negedge clk) begin
    if (mem_read === 1'b1) rd_cycles++;
    if (mem_write === 1'b1) wr_cycles++;
    if (reset_n !== 1'b1 || !(mem_read === 1'b1 || mem_write === 1'b1) || mem_resp) begin
      cnt = 0;
      mem_resp = stray;
    end else begin
      mem_resp = (cnt == wait_n);
      cnt++;
    end
    if (mem_resp && mem_read === 1'b1) rd_log.push_back(mem_address);
    if (mem_resp && mem_write === 1'b1) begin
      if (mem_wmask[0]) mem[mem_address[15:1]][7:0] = mem_wdata[7:0];
      if (mem_wmask[1]) mem[mem_address[15:1]][15:8] = mem_wdata[15:8];
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h mask=%b", mem_address, mem_wdata, mem_wmask);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        if (mem_address !== w.a || mem_wdata !== w.d || mem_wmask !== w.m) begin
          failures++;
          $display("FAIL write got=%h/%h/%b exp=%h/%h/%b", mem_address, mem_wdata, mem_wmask, w.a, w.d, w.m);
        end
      end
    end
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      checks++;
      if (rsp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp data=%h", rsp_data);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        if (rsp_data !== r.d0 || s_rsp_data !== r.d1 || s_rsp_valid !== 1'b1) begin
          failures++;
          $display("FAIL rsp_data got=%h/%h exp=%h/%h", rsp_data, s_rsp_data, r.d0, r.d1);
        end
      end
    end
  end
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] w);
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got=%b exp=1", req_ready);
    end
    req_valid = 1;
    req_op = op;
    req_addr = a;
    req_wdata = w;
    @(posedge clk);
    #1;
    req_valid = 0;
    req_op = 3'($urandom);
    req_addr = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 200);
  endtask
  task automatic run(input logic [2:0] op, input logic [15:0] a, input logic [15:0] w,
                     input logic [15:0] d0, input logic [15:0] d1, output int lat);
    rsp_q.push_back({d0, d1});
    send(op, a, w);
    wait_rsp(lat);
  endtask
  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 0 || rsp_valid !== 0 || rsp_data !== 0) begin
      failures++;
      $display("FAIL reset_rsp got=%b/%b/%h exp=0/0/0000", req_ready, rsp_valid, rsp_data);
    end
    checks++;
    if (mem_read !== 0 || mem_write !== 0 || mem_wmask !== 0 || mem_wdata !== 0 || mem_address !== 0) begin
      failures++;
      $display("FAIL reset_mem got=%b/%b/%b/%h/%h exp=all zero", mem_read, mem_write, mem_wmask, mem_wdata, mem_address);
    end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
  endtask
  task automatic test_ldr;
    int lat;
    mem[16'h1234 >> 1] = 16'hBEEF;
    wait_n = 2;
    rd_cycles = 0;
    rd_log.delete();
    run(mop_ldr, 16'h1235, 16'h0, 16'hBEEF, 16'hBEEF, lat);
    last0 = 16'hBEEF;
    last1 = 16'hBEEF;
    checks++;
    if (lat != 5) begin failures++; $display("FAIL ldr_latency got=%0d exp=5", lat); end
    checks++;
    if (rd_cycles != 3) begin failures++; $display("FAIL ldr_read_cycles got=%0d exp=3", rd_cycles); end
    checks++;
    if (rd_log.size() != 1 || rd_log[0] !== 16'h1234) begin
      failures++;
      $display("FAIL ldr_addr got_n=%0d exp=1 at 1234", rd_log.size());
    end
    checks++;
    if (req_ready !== 1) begin failures++; $display("FAIL ldr_ready_with_rsp got=%b exp=1", req_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 0 || rsp_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL ldr_pulse got=%b/%h exp=0/beef", rsp_valid, rsp_data);
    end
    wait_n = 0;
  endtask
  task automatic test_ldb;
    int lat;
    mem[16'h2000 >> 1] = 16'h80FF;
    mem[16'h2002 >> 1] = 16'h7F00;
    run(mop_ldb, 16'h2001, 16'h0, 16'h0080, 16'hFF80, lat);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL ldb_latency got=%0d exp=3", lat); end
    run(mop_ldb, 16'h2000, 16'h0, 16'h00FF, 16'hFFFF, lat);
    run(mop_ldb, 16'h2003, 16'h0, 16'h007F, 16'h007F, lat);
    last0 = 16'h007F;
    last1 = 16'h007F;
  endtask
  task automatic test_stb;
    int lat;
    mem[16'h3000 >> 1] = 16'h0;
    wr_cycles = 0;
    wr_q.push_back({16'h3001, 16'hABAB, 2'b10});
    run(mop_stb, 16'h3001, 16'h12AB, last0, last1, lat);
    checks++;
    if (lat != 3 || wr_cycles != 1) begin
      failures++;
      $display("FAIL stb_timing got=%0d/%0d exp=3/1", lat, wr_cycles);
    end
    wr_q.push_back({16'h3000, 16'hCDCD, 2'b01});
    run(mop_stb, 16'h3000, 16'h55CD, last0, last1, lat);
    checks++;
    if (mem[16'h3000 >> 1] !== 16'hABCD) begin
      failures++;
      $display("FAIL stb_merge got=%h exp=abcd", mem[16'h3000 >> 1]);
    end
    wr_q.push_back({16'h3002, 16'h1357, 2'b11});
    run(mop_str, 16'h3003, 16'h1357, last0, last1, lat);
  endtask
  task automatic test_sti_ldi;
    int lat;
    mem[16'h4000 >> 1] = 16'h5003;
    rd_log.delete();
    wr_q.push_back({16'h5002, 16'h7777, 2'b11});
    run(mop_sti, 16'h4000, 16'h7777, last0, last1, lat);
    checks++;
    if (lat != 5) begin failures++; $display("FAIL sti_latency got=%0d exp=5", lat); end
    checks++;
    if (rd_log.size() != 1 || rd_log[0] !== 16'h4000 || mem[16'h5002 >> 1] !== 16'h7777) begin
      failures++;
      $display("FAIL sti_path got_n=%0d mem=%h exp=1 7777", rd_log.size(), mem[16'h5002 >> 1]);
    end
    wait_n = 1;
    rd_log.delete();
    run(mop_ldi, 16'h4001, 16'h0, 16'h7777, 16'h7777, lat);
    last0 = 16'h7777;
    last1 = 16'h7777;
    checks++;
    if (lat != 7) begin failures++; $display("FAIL ldi_latency got=%0d exp=7", lat); end
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== 16'h4000 || rd_log[1] !== 16'h5002) begin
      failures++;
      $display("FAIL ldi_addrs got_n=%0d exp=2 (4000,5002)", rd_log.size());
    end
    wait_n = 0;
  endtask
  task automatic test_reset_mid;
    int n = 0, seen;
    wait_n = 20;
    rd_log.delete();
    send(mop_ldi, 16'h4000, 16'h0);
    while (!(rd_log.size() == 1 && mem_read === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL rstmid_second_read got=timeout exp=strobe"); end
    seen = rsp_count;
    reset_n = 0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_read !== 0 || mem_write !== 0) begin
      failures++;
      $display("FAIL rstmid_strobes got=%b/%b exp=0/0", mem_read, mem_write);
    end
    reset_n = 1;
    stray = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    stray = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rsp_count != seen || req_ready !== 1 || rsp_data !== 0) begin
      failures++;
      $display("FAIL rstmid_idle got=%0d/%b/%h exp=%0d/1/0000", rsp_count, req_ready, rsp_data, seen);
    end
    last0 = 0;
    last1 = 0;
    wait_n = 0;
  endtask
  task automatic test_unused;
    int acc = 0;
    int lat;
    run(mop_ldr, 16'h1234, 16'h0, 16'hBEEF, 16'hBEEF, lat);
    rd_cycles = 0;
    wr_cycles = 0;
    repeat (4) rsp_q.push_back({16'h0, 16'h0});
    @(negedge clk);
    req_valid = 1;
    req_op = 3'd6;
    repeat (8) begin
      if (req_ready === 1'b1) acc++;
      @(negedge clk);
    end
    req_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (acc != 4) begin failures++; $display("FAIL unused_accepts got=%0d exp=4", acc); end
    checks++;
    if (rd_cycles + wr_cycles != 0 || rsp_q.size() != 0) begin
      failures++;
      $display("FAIL unused_strobes got=%0d pending=%0d exp=0/0", rd_cycles + wr_cycles, rsp_q.size());
    end
    last0 = 0;
    last1 = 0;
  endtask
  task automatic test_back_to_back;
    int lat;
    mem[16'h0100 >> 1] = 16'hA5A5;
    run(mop_ldr, 16'h0100, 16'h0, 16'hA5A5, 16'hA5A5, lat);
    checks++;
    if (req_ready !== 1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
    wr_q.push_back({16'h0102, 16'h2468, 2'b11});
    run(mop_str, 16'h0102, 16'h2468, 16'hA5A5, 16'hA5A5, lat);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_q.size() != 0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL pending got=%0d/%0d exp=0/0", rsp_q.size(), wr_q.size());
    end
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
    test_reset;
    test_ldr;
    test_ldb;
    test_stb;
    test_sti_ldi;
    test_reset_mid;
    test_unused;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
